// File: rtl/uart_rx_cfg.sv
// UART receiver with elaboration-time data width, parity and stop bits.
// Flags parity, framing and break conditions with each received word.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q;
  logic                 sync1_q;
  logic                 sync2_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 stop_idx_q;
  logic                 ferr_q;
  logic                 stop0_low_q;

  logic s;
  logic ferr_d;
  logic brk_d;
  logic perr_d;
  logic par_exp;

  assign s = sync2_q;

  // Final-sample flag evaluation; stop0 is the first stop sample.
  always_comb begin
    par_exp = (PARITY == 2) ? ~^shift_q : ^shift_q;
    ferr_d  = ferr_q | ~s;
    brk_d   = ((stop_idx_q == 1'b0) ? ~s : stop0_low_q)
            & ~|shift_q
            & ((PARITY == 0) | ~par_q);
    perr_d  = (PARITY != 0) & (par_q != par_exp);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop_idx_q   <= 1'b0;
      ferr_q       <= 1'b0;
      stop0_low_q  <= 1'b0;
      o_RX_DV      <= 1'b0;
      o_RX_Data    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      sync1_q <= i_RX_Serial;
      sync2_q <= sync1_q;
      o_RX_DV <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cnt_q       <= '0;
          bit_idx_q   <= '0;
          stop_idx_q  <= 1'b0;
          ferr_q      <= 1'b0;
          stop0_low_q <= 1'b0;
          if (!s) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            state_q <= s ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= s;
            if (bit_idx_q == BIT_LAST) begin
              bit_idx_q <= '0;
              state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            par_q   <= s;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q  <= '0;
            ferr_q <= ferr_d;
            if (stop_idx_q == 1'b0) stop0_low_q <= ~s;
            if (stop_idx_q == STOP_LAST) begin
              o_RX_DV      <= 1'b1;
              o_RX_Data    <= shift_q;
              o_Parity_Err <= perr_d;
              o_Frame_Err  <= ferr_d;
              o_Break      <= brk_d;
              state_q      <= ferr_d ? S_WAIT_HIGH : S_IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          cnt_q <= '0;
          if (s) state_q <= S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg across four parameter sets.
// Each instance has its own serial line; DV pulses are counted.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx [4] = '{1'b1, 1'b1, 1'b1, 1'b1};

  logic       dv0, dv1, dv2, dv3;
  logic [7:0] d0, d1, d3;
  logic [6:0] d2;
  logic       pe0, pe1, pe2, pe3;
  logic       fe0, fe1, fe2, fe3;
  logic       bk0, bk1, bk2, bk3;

  int dvc [4] = '{0, 0, 0, 0};
  int errors = 0;
  int checks = 0;
  int b;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx[0]),
    .o_RX_DV(dv0), .o_RX_Data(d0), .o_Parity_Err(pe0),
    .o_Frame_Err(fe0), .o_Break(bk0));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx[1]),
    .o_RX_DV(dv1), .o_RX_Data(d1), .o_Parity_Err(pe1),
    .o_Frame_Err(fe1), .o_Break(bk1));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u2 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx[2]),
    .o_RX_DV(dv2), .o_RX_Data(d2), .o_Parity_Err(pe2),
    .o_Frame_Err(fe2), .o_Break(bk2));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u3 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx[3]),
    .o_RX_DV(dv3), .o_RX_Data(d3), .o_Parity_Err(pe3),
    .o_Frame_Err(fe3), .o_Break(bk3));

  always @(negedge clk) begin
    if (dv0) dvc[0]++;
    if (dv1) dvc[1]++;
    if (dv2) dvc[2]++;
    if (dv3) dvc[3]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input int k, input logic v);
    rx[k] = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int k, input logic [8:0] d, input int db,
                            input bit has_par, input logic pb,
                            input int ns, input logic st2);
    send_bit(k, 1'b0);
    for (int i = 0; i < db; i++) send_bit(k, d[i]);
    if (has_par) send_bit(k, pb);
    send_bit(k, 1'b1);
    if (ns == 2) send_bit(k, st2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dv", 32'(dv0), 0);
    chk("rst_data", 32'(d0), 0);
    chk("rst_flags", {29'd0, pe0, fe0, bk0}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Back-to-back frames, no parity
    b = dvc[0];
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1);
    chk("t1a_dv", 32'(dvc[0] - b), 1);
    chk("t1a_data", 32'(d0), 32'hA5);
    chk("t1a_flags", {29'd0, pe0, fe0, bk0}, 0);
    send_frame(0, 9'h000, 8, 0, 1'b0, 1, 1'b1);
    send_bit(0, 1'b1);
    chk("t1b_dv", 32'(dvc[0] - b), 2);
    chk("t1b_data", 32'(d0), 0);
    chk("t1b_flags", {29'd0, pe0, fe0, bk0}, 0);

    // Even parity
    b = dvc[1];
    send_frame(1, 9'h003, 8, 1, 1'b0, 1, 1'b1);
    send_bit(1, 1'b1);
    chk("t2a_dv", 32'(dvc[1] - b), 1);
    chk("t2a_data", 32'(d1), 32'h03);
    chk("t2a_perr", 32'(pe1), 0);
    send_frame(1, 9'h003, 8, 1, 1'b1, 1, 1'b1);
    send_bit(1, 1'b1);
    chk("t2b_dv", 32'(dvc[1] - b), 2);
    chk("t2b_data", 32'(d1), 32'h03);
    chk("t2b_perr", 32'(pe1), 1);
    chk("t2b_fe_bk", {30'd0, fe1, bk1}, 0);

    // Odd parity, 7 data bits
    b = dvc[2];
    send_frame(2, 9'h041, 7, 1, 1'b1, 1, 1'b1);
    send_bit(2, 1'b1);
    chk("t3_dv", 32'(dvc[2] - b), 1);
    chk("t3_data", 32'(d2), 32'h41);
    chk("t3_flags", {29'd0, pe2, fe2, bk2}, 0);

    // Start-bit glitch then a real frame
    b = dvc[0];
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    repeat (300) @(negedge clk);
    chk("t4_glitch_dv", 32'(dvc[0] - b), 0);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b1);
    send_bit(0, 1'b1);
    chk("t4_dv", 32'(dvc[0] - b), 1);
    chk("t4_data", 32'(d0), 32'h3C);
    chk("t4_flags", {29'd0, pe0, fe0, bk0}, 0);

    // Two stop bits, second one low, line lingers low
    b = dvc[3];
    send_frame(3, 9'h05A, 8, 0, 1'b0, 2, 1'b0);
    repeat (40) @(negedge clk);
    rx[3] = 1'b1;
    repeat (250) @(negedge clk);
    chk("t5_dv", 32'(dvc[3] - b), 1);
    chk("t5_data", 32'(d3), 32'h5A);
    chk("t5_ferr", 32'(fe3), 1);
    chk("t5_brk", 32'(bk3), 0);
    send_frame(3, 9'h011, 8, 0, 1'b0, 2, 1'b1);
    send_bit(3, 1'b1);
    chk("t5b_dv", 32'(dvc[3] - b), 2);
    chk("t5b_data", 32'(d3), 32'h11);
    chk("t5b_flags", {29'd0, pe3, fe3, bk3}, 0);

    // Break: 20 bit-times low
    b = dvc[0];
    rx[0] = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    rx[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("t6_dv", 32'(dvc[0] - b), 1);
    chk("t6_data", 32'(d0), 0);
    chk("t6_brk", 32'(bk0), 1);
    chk("t6_ferr", 32'(fe0), 1);
    chk("t6_perr", 32'(pe0), 0);
    send_frame(0, 9'h081, 8, 0, 1'b0, 1, 1'b1);
    send_bit(0, 1'b1);
    chk("t6b_dv", 32'(dvc[0] - b), 2);
    chk("t6b_data", 32'(d0), 32'h81);
    chk("t6b_flags", {29'd0, pe0, fe0, bk0}, 0);

    // Reset during data bit 3
    b = dvc[0];
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    rx[0] = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_data", 32'(d0), 0);
    chk("t7_rst_outs", {28'd0, dv0, pe0, fe0, bk0}, 0);
    rx[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("t7_dv", 32'(dvc[0] - b), 0);
    chk("t7_data", 32'(d0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
